pipeline_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.

---
 rtl/cpu_types_pkg.sv | 38 +++
 rtl/hazard_detect.sv | 16 +
 rtl/pipeline_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline controller: FSM states, register index, latch control bundle.
// No logic; constants only.
package cpu_types_pkg;

    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTING = 2'd2,
        HALTED  = 2'd3
    } pctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
        logic memwb_flush;
    } latch_ctl_t;

    // Flushed latches keep en=1; every latch resolves flush before en.
    localparam latch_ctl_t CTL_IDLE     = latch_ctl_t'(9'b000000000);
    localparam latch_ctl_t CTL_ADVANCE  = latch_ctl_t'(9'b110101010);
    localparam latch_ctl_t CTL_BUBBLE   = latch_ctl_t'(9'b011101010);
    localparam latch_ctl_t CTL_LOADUSE  = latch_ctl_t'(9'b000111010);
    localparam latch_ctl_t CTL_REDIRECT = latch_ctl_t'(9'b111111110);
    localparam latch_ctl_t CTL_HALT     = latch_ctl_t'(9'b011111110);
    localparam latch_ctl_t CTL_JUMP     = latch_ctl_t'(9'b111101010);
    localparam latch_ctl_t CTL_HALTING  = latch_ctl_t'(9'b000000010);

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between ID/EX load destination and IF/ID sources.
// Combinational, zero latency; no flow control.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             dREN_ex,
    input  logic [REG_W-1:0] rt_ex,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    output logic             load_use
);

    // Register zero is hardwired, so a load targeting it can never create a dependency.
    assign load_use = dREN_ex && (rt_ex != '0) && ((rt_ex == rs_id) || (rt_ex == rt_id));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline latch/PC sequencer with RUN/MEMWAIT/HALTING/HALTED FSM; optional STALL_CNT_EN counters.
// Latch controls combinational from state+inputs; halt and counters registered (1 cycle).
// Backpressure: a missing ihit/dhit freezes every latch and the PC until the access completes.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_mem,
    input  logic             dWEN_mem,
    input  logic             PCsrc_mem,
    input  logic             jump_id,
    input  logic             halt_mem,
    input  logic             dREN_ex,
    input  logic [REG_W-1:0] rt_ex,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pctrl_state_t state, state_n;
    latch_ctl_t   ctl;
    logic         mem_acc;
    logic         step;
    logic         run_like;
    logic         load_use;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .dREN_ex  (dREN_ex),
        .rt_ex    (rt_ex),
        .rs_id    (rs_id),
        .rt_id    (rt_id),
        .load_use (load_use)
    );

    assign mem_acc  = dREN_mem | dWEN_mem;
    assign step     = mem_acc ? dhit : ihit;
    assign run_like = (state == RUN) || (state == MEMWAIT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
            halt  <= 1'b0;
        end else begin
            state <= state_n;
            halt  <= (state_n == HALTED);
        end
    end

    always_comb begin
        ctl     = CTL_IDLE;
        state_n = state;
        case (state)
            RUN, MEMWAIT: begin
                if (!step) begin
                    state_n = mem_acc ? MEMWAIT : RUN;
                end else begin
                    state_n = RUN;
                    ctl     = CTL_ADVANCE;
                    if (halt_mem) begin
                        ctl     = CTL_HALT;
                        state_n = HALTING;
                    end else if (PCsrc_mem) begin
                        ctl = CTL_REDIRECT;
                    end else if (load_use) begin
                        ctl = CTL_LOADUSE;
                    end else if (jump_id) begin
                        ctl = CTL_JUMP;
                    end else if (mem_acc && !ihit) begin
                        // Data side finished but fetch did not: drain a bubble, refetch same PC.
                        ctl = CTL_BUBBLE;
                    end
                end
            end
            HALTING: begin
                ctl     = CTL_HALTING;
                state_n = HALTED;
            end
            HALTED: begin
                ctl     = CTL_IDLE;
                state_n = HALTED;
            end
            default: state_n = RUN;
        endcase
    end

    assign pc_en       = ctl.pc_en;
    assign ifid_en     = ctl.ifid_en;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_en     = ctl.idex_en;
    assign idex_flush  = ctl.idex_flush;
    assign exmem_en    = ctl.exmem_en;
    assign exmem_flush = ctl.exmem_flush;
    assign memwb_en    = ctl.memwb_en;
    assign memwb_flush = ctl.memwb_flush;

`ifdef STALL_CNT_EN
    logic             stall_ev;
    logic             flush_ev;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Events mirror the priority chain: a jump hidden behind a load-use stall is not a flush.
    assign stall_ev = run_like && (!step || (!halt_mem && !PCsrc_mem && load_use));
    assign flush_ev = run_like && step && (halt_mem || PCsrc_mem || (jump_id && !load_use));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_ev && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (flush_ev && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    logic unused_run_like;
    assign unused_run_like = run_like;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl; counter expectations follow STALL_CNT_EN.
module tb_pipeline_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}
    localparam logic [8:0] E_IDLE     = 9'b0_00_00_00_00;
    localparam logic [8:0] E_ADVANCE  = 9'b1_10_10_10_10;
    localparam logic [8:0] E_BUBBLE   = 9'b0_11_10_10_10;
    localparam logic [8:0] E_LOADUSE  = 9'b0_00_11_10_10;
    localparam logic [8:0] E_REDIRECT = 9'b1_11_11_11_10;
    localparam logic [8:0] E_HALT     = 9'b0_11_11_11_10;
    localparam logic [8:0] E_JUMP     = 9'b1_11_10_10_10;
    localparam logic [8:0] E_HALTING  = 9'b0_00_00_00_10;

    typedef struct {
        string            tag;
        logic [8:0]       ctl;
        logic             halt;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST;
    logic ihit, dhit, dREN_mem, dWEN_mem, PCsrc_mem, jump_id, halt_mem, dREN_ex;
    logic [REG_W-1:0] rt_ex, rs_id, rt_id;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0] obs_ctl;

    exp_t sb[$];
    int tests  = 0;
    int failed = 0;
    logic [CNT_W-1:0] stall_m = '0;
    logic [CNT_W-1:0] flush_m = '0;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .PCsrc_mem(PCsrc_mem),
        .jump_id(jump_id), .halt_mem(halt_mem), .dREN_ex(dREN_ex),
        .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign obs_ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                      exmem_en, exmem_flush, memwb_en, memwb_flush};

    task automatic set_in(input logic ih, input logic dh, input logic drm, input logic dwm,
                          input logic pcs, input logic jmp, input logic hlt, input logic drx,
                          input int rtx, input int rsi, input int rti);
        ihit = ih; dhit = dh; dREN_mem = drm; dWEN_mem = dwm;
        PCsrc_mem = pcs; jump_id = jmp; halt_mem = hlt; dREN_ex = drx;
        rt_ex = REG_W'(rtx); rs_id = REG_W'(rsi); rt_id = REG_W'(rti);
    endtask

    task automatic push_exp(input string tag, input logic [8:0] c, input logic h);
        exp_t e;
        e.tag = tag; e.ctl = c; e.halt = h; e.stall = stall_m; e.flush = flush_m;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        tests++;
        assert (sb.size() != 0) else begin
            failed++;
            $error("FAIL scoreboard_empty observed=0 entries expected>=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            tests++;
            assert (obs_ctl === e.ctl) else begin
                failed++;
                $error("FAIL %s.ctl observed=%b expected=%b", e.tag, obs_ctl, e.ctl);
            end
            tests++;
            assert (halt === e.halt) else begin
                failed++;
                $error("FAIL %s.halt observed=%b expected=%b", e.tag, halt, e.halt);
            end
            tests++;
            assert (stall_cnt === e.stall) else begin
                failed++;
                $error("FAIL %s.stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt, e.stall);
            end
            tests++;
            assert (flush_cnt === e.flush) else begin
                failed++;
                $error("FAIL %s.flush_cnt observed=%0d expected=%0d", e.tag, flush_cnt, e.flush);
            end
        end
    endtask

    // Counter model advances as the clock edge at the end of the cycle would.
    task automatic model_tick(input bit st, input bit fl);
`ifdef STALL_CNT_EN
        if (st && stall_m != '1) stall_m = stall_m + 1'b1;
        if (fl && flush_m != '1) flush_m = flush_m + 1'b1;
`else
        if (st || fl) begin
            stall_m = '0;
            flush_m = '0;
        end
`endif
    endtask

    task automatic step(input string tag, input logic [8:0] c, input logic h,
                        input bit st, input bit fl);
        push_exp(tag, c, h);
        @(negedge CLK);
        compare();
        model_tick(st, fl);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_cycle(input bit st);
        @(negedge CLK);
        model_tick(st, 1'b0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        push_exp("reset", E_IDLE, 1'b0);
        #1;
        compare();
        nRST = 1'b1;

        // Free-running fetch with no hazards.
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("run", E_ADVANCE, 1'b0, 0, 0);

        // Load waiting on the data cache, then data done but fetch not.
        set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("memwait", E_IDLE, 1'b0, 1, 0);
        set_in(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("dhit_bubble", E_BUBBLE, 1'b0, 0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("resume", E_ADVANCE, 1'b0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("imiss", E_IDLE, 1'b0, 1, 0);

        // Load-use compare, including register zero and a non-load producer.
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 8, 8, 0);
        step("lu_rs", E_LOADUSE, 1'b0, 1, 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 8, 3, 8);
        step("lu_rt", E_LOADUSE, 1'b0, 1, 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("lu_r0", E_ADVANCE, 1'b0, 0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 8, 3, 4);
        step("lu_nomatch", E_ADVANCE, 1'b0, 0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 8, 8, 8);
        step("lu_noload", E_ADVANCE, 1'b0, 0, 0);

        // Redirect beats load-use; redirect under a store completing.
        set_in(1, 0, 0, 0, 1, 0, 0, 1, 8, 8, 0);
        step("redirect_lu", E_REDIRECT, 1'b0, 0, 1);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("after_redirect", E_ADVANCE, 1'b0, 0, 0);
        set_in(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        step("redirect_store", E_REDIRECT, 1'b0, 0, 1);

        // Jump, and jump losing to load-use.
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("jump", E_JUMP, 1'b0, 0, 1);
        set_in(1, 0, 0, 0, 0, 1, 0, 1, 9, 0, 9);
        step("jump_lu", E_LOADUSE, 1'b0, 1, 0);

        // Halt retirement, terminal state, async reset out of it.
        set_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("halt_flush", E_HALT, 1'b0, 0, 1);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("halting", E_HALTING, 1'b0, 0, 0);
        step("halted", E_IDLE, 1'b1, 0, 0);
        set_in(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        step("halted_hold", E_IDLE, 1'b1, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        nRST = 1'b0;
        stall_m = '0;
        flush_m = '0;
        #1;
        push_exp("async_reset", E_IDLE, 1'b0);
        #1;
        compare();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("post_reset", E_ADVANCE, 1'b0, 0, 0);

        // Long fetch stall drives the stall counter into saturation.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < (1 << CNT_W) + 2; i++) idle_cycle(1'b1);
        step("stall_sat", E_IDLE, 1'b0, 1, 0);
        step("stall_sat_hold", E_IDLE, 1'b0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
